// File: rtl/if_prefetch_queue_if.sv
// Instruction-memory port of the fetch front end: in-order request channel plus response channel.
interface if_prefetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues in-order imem requests under a queue credit,
// buffers returned instructions with their PCs and flushes on redirect, dropping stale responses.
module if_prefetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  if_prefetch_queue_if.master      imem,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc,
  input  logic                     stall,
  output logic                     if_valid,
  output logic [63:0]              if_pc,
  output logic [31:0]              if_instr,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);
  localparam logic [CW-1:0] FULL_W  = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_W   = OW'(MAX_OUTST);
  localparam logic [PW-1:0] PF_LAST = PW'(MAX_OUTST - 1);

  function automatic logic [PW-1:0] pf_next(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == PF_LAST) begin
      nxt = '0;
    end else begin
      nxt = ptr + 1'b1;
    end
    return nxt;
  endfunction

  logic [63:0]   fetch_pc_r;
  logic [OW-1:0] out_cnt_r;
  logic [OW-1:0] drop_cnt_r;
  logic [OW-1:0] out_next_s;
  logic [CW-1:0] count_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [63:0]   pc_q_r    [DEPTH];
  logic [31:0]   instr_q_r [DEPTH];
  logic [63:0]   pf_pc_r   [MAX_OUTST];
  logic [PW-1:0] pf_wr_r;
  logic [PW-1:0] pf_rd_r;
  logic [SW-1:0] credit_sum_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          resp_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;

  // Issue credit and push/pop decisions; credit uses registered occupancy only.
  always_comb begin
    credit_sum_s = SW'(count_r) + SW'(out_cnt_r);
    req_valid_s  = reset && !redirect && (credit_sum_s < DEPTH_W) && (out_cnt_r < MAX_W);
    req_fire_s   = req_valid_s && imem.imem_req_ready;
    resp_s       = imem.imem_resp_valid;
    push_s       = resp_s && (drop_cnt_r == '0) && !redirect;
    pop_s        = (count_r != '0) && !stall && !redirect;
    full_s       = (count_r == FULL_W);
    out_next_s   = out_cnt_r + OW'(req_fire_s) - OW'(resp_s);
  end

  assign imem.imem_req_valid = req_valid_s;
  assign imem.imem_req_addr  = fetch_pc_r;

  // Fetch PC, in-flight count and stale-response drop count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC;
      out_cnt_r  <= '0;
      drop_cnt_r <= '0;
    end else begin
      out_cnt_r <= out_next_s;
      if (redirect) begin
        // Every request still in flight after this cycle belongs to the flushed path.
        fetch_pc_r <= redirect_pc & ~64'h3;
        drop_cnt_r <= out_next_s;
      end else begin
        if (req_fire_s) begin
          fetch_pc_r <= fetch_pc_r + 64'd4;
        end
        if (resp_s && (drop_cnt_r != '0)) begin
          drop_cnt_r <= drop_cnt_r - 1'b1;
        end
      end
    end
  end

  // PCs of accepted requests, consumed in order as responses return (dropped or not).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_wr_r <= '0;
      pf_rd_r <= '0;
      for (int i = 0; i < int'(MAX_OUTST); i++) begin
        pf_pc_r[i] <= 64'h0;
      end
    end else begin
      if (req_fire_s) begin
        pf_pc_r[pf_wr_r] <= fetch_pc_r;
        pf_wr_r          <= pf_next(pf_wr_r);
      end
      if (resp_s) begin
        pf_rd_r <= pf_next(pf_rd_r);
      end
    end
  end

  // Instruction queue; redirect empties it and overrides both push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q_r[i]    <= 64'h0;
        instr_q_r[i] <= 32'h0;
      end
    end else if (redirect) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        pc_q_r[wr_ptr_r]    <= pf_pc_r[pf_rd_r];
        instr_q_r[wr_ptr_r] <= imem.imem_resp_data;
        wr_ptr_r            <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Head of queue straight from registered storage; zeros when empty.
  always_comb begin
    if (count_r != '0) begin
      if_valid = 1'b1;
      if_pc    = pc_q_r[rd_ptr_r];
      if_instr = instr_q_r[rd_ptr_r];
    end else begin
      if_valid = 1'b0;
      if_pc    = 64'h0;
      if_instr = 32'h0;
    end
  end

  assign queue_count = count_r;

  if_prefetch_queue_chk #(
    .MAX_OUTST (MAX_OUTST),
    .OW        (OW)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .full    (full_s),
    .resp    (resp_s),
    .out_cnt (out_cnt_r)
  );

endmodule

// Protocol checks on the prefetch queue internals.
module if_prefetch_queue_chk #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned OW        = 2
) (
  input logic          clk,
  input logic          reset,
  input logic          push,
  input logic          full,
  input logic          resp,
  input logic [OW-1:0] out_cnt
);

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));
  a_outst_max:    assert property (@(posedge clk) disable iff (!reset) out_cnt <= OW'(MAX_OUTST));
  a_resp_owed:    assert property (@(posedge clk) disable iff (!reset) resp |-> (out_cnt != '0));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: queue-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_if_prefetch_queue;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [63:0] RESET_PC  = 64'h0;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [63:0] addr; int due; } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic [$clog2(DEPTH):0] queue_count;

  if_prefetch_queue_if imem();

  if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit rand_ready = 1'b0;

  ent_t        mq[$];
  logic [63:0] mfl[$];
  logic [63:0] m_fpc;
  int          m_out;
  int          m_drop;
  req_t        envq[$];

  logic        s_valid, s_req, s_resp;
  logic [63:0] s_pc, s_addr;
  logic [31:0] s_instr;
  logic [63:0] s_count;
  logic [63:0] last_pc;
  bit          have_last = 1'b0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A0013;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mfl.delete();
    envq.delete();
    m_fpc = RESET_PC;
    m_out = 0;
    m_drop = 0;
    have_last = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_resp_valid = 1'b0;
    imem.imem_resp_data = 32'h0;
    #1;
    chk({tag, "_if_valid"}, 64'(if_valid), 64'd0);
    chk({tag, "_if_pc"}, if_pc, 64'd0);
    chk({tag, "_if_instr"}, 64'(if_instr), 64'd0);
    chk({tag, "_count"}, 64'(queue_count), 64'd0);
    chk({tag, "_req_valid"}, 64'(imem.imem_req_valid), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock cycle: drive memory side, compare against the model, advance model and memory.
  task automatic step();
    logic        ready, resp, m_req, fire, fire_dut;
    logic [63:0] rpc;
    ent_t        e;
    req_t        r;
    ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    resp  = (envq.size() > 0) && (envq[0].due <= cyc);
    imem.imem_req_ready  = ready;
    imem.imem_resp_valid = resp;
    imem.imem_resp_data  = resp ? mem_word(envq[0].addr) : 32'h0;
    #1;
    s_valid = if_valid;
    s_pc    = if_pc;
    s_instr = if_instr;
    s_count = 64'(queue_count);
    s_req   = imem.imem_req_valid;
    s_addr  = imem.imem_req_addr;
    s_resp  = resp;
    m_req = !redirect && (mq.size() + m_out < DEPTH) && (m_out < MAX_OUTST);
    chk("if_valid", 64'(s_valid), (mq.size() > 0) ? 64'd1 : 64'd0);
    chk("if_pc", s_pc, (mq.size() > 0) ? mq[0].pc : 64'd0);
    chk("if_instr", 64'(s_instr), (mq.size() > 0) ? 64'(mq[0].instr) : 64'd0);
    chk("queue_count", s_count, 64'(mq.size()));
    chk("req_valid", 64'(s_req), 64'(m_req));
    if (m_req) chk("req_addr", s_addr, m_fpc);
    chk("outst_within_max", (envq.size() <= MAX_OUTST) ? 64'd1 : 64'd0, 64'd1);
    if (s_valid && !stall && !redirect) begin
      if (have_last) chk("pop_sequence", s_pc, last_pc + 64'd4);
      last_pc = s_pc;
      have_last = 1'b1;
    end
    if (redirect) have_last = 1'b0;
    fire = m_req && ready;
    rpc = 64'h0;
    if (resp) begin
      if (mfl.size() > 0) rpc = mfl.pop_front();
      if (m_out > 0) m_out--;
    end
    if (redirect) begin
      mq.delete();
      m_drop = m_out;
      m_fpc = redirect_pc & ~64'h3;
    end else begin
      if (mq.size() > 0 && !stall) void'(mq.pop_front());
      if (resp) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          e.pc = rpc;
          e.instr = mem_word(rpc);
          mq.push_back(e);
        end
      end
    end
    if (fire) begin
      mfl.push_back(m_fpc);
      m_fpc = m_fpc + 64'd4;
      m_out++;
    end
    fire_dut = s_req && ready;
    @(posedge clk);
    if (resp) void'(envq.pop_front());
    if (fire_dut) begin
      r.addr = s_addr;
      r.due  = cyc + $urandom_range(lat_min, lat_max);
      if (envq.size() > 0 && r.due <= envq[$].due) r.due = envq[$].due + 1;
      envq.push_back(r);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    step();
    while (!s_valid && n < 20) begin
      step();
      n++;
    end
    chk(nm, 64'(s_valid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    imem.imem_req_ready = 1'b0;
    imem.imem_resp_valid = 1'b0;
    imem.imem_resp_data = 32'h0;
    @(negedge clk);
    do_reset("rst");

    // 1: one instruction per cycle from cycle 2
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) begin
        chk("t1_req_c0", 64'(s_req), 64'd1);
        chk("t1_valid_c0", 64'(s_valid), 64'd0);
      end
      if (k == 2) begin
        chk("t1_valid_c2", 64'(s_valid), 64'd1);
        chk("t1_pc_c2", s_pc, 64'h0);
        chk("t1_instr_c2", 64'(s_instr), 64'h5A5A0013);
      end
      if (k == 3) chk("t1_pc_c3", s_pc, 64'h4);
      if (k == 4) chk("t1_pc_c4", s_pc, 64'h8);
    end

    // 2: stall fills the queue and exhausts credit
    stall = 1'b1;
    repeat (6) step();
    chk("t2_count_full", s_count, 64'd4);
    chk("t2_req_blocked", 64'(s_req), 64'd0);
    chk("t2_head_held", s_pc, 64'h20);
    stall = 1'b0;
    repeat (8) step();

    // 3: redirect with two requests in flight
    lat_min = 3;
    lat_max = 3;
    n = 0;
    while (envq.size() != 2 && n < 12) begin
      step();
      n++;
    end
    chk("t3_two_inflight", 64'(envq.size()), 64'd2);
    redirect = 1'b1;
    redirect_pc = 64'h100;
    step();
    chk("t3_no_req_in_redirect", 64'(s_req), 64'd0);
    redirect = 1'b0;
    step();
    chk("t3_count_flushed", s_count, 64'd0);
    chk("t3_valid_flushed", 64'(s_valid), 64'd0);
    wait_valid("t3_valid_timeout");
    chk("t3_target_pc", s_pc, 64'h100);
    chk("t3_target_instr", 64'(s_instr), 64'h5A5A0113);

    // 4: redirect, stall and response together; redirect wins
    lat_min = 1;
    lat_max = 1;
    repeat (6) step();
    stall = 1'b1;
    step();
    redirect = 1'b1;
    redirect_pc = 64'h206;
    step();
    chk("t4_resp_in_redirect", 64'(s_resp), 64'd1);
    redirect = 1'b0;
    stall = 1'b0;
    step();
    chk("t4_count_flushed", s_count, 64'd0);
    wait_valid("t4_valid_timeout");
    chk("t4_target_pc", s_pc, 64'h204);
    chk("t4_target_instr", 64'(s_instr), 64'h5A5A0217);

    // 5: random ready, latency 1..4, occasional stall and redirect
    rand_ready = 1'b1;
    lat_min = 1;
    lat_max = 4;
    for (int k = 0; k < 400; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 29) == 0);
      redirect_pc = {32'h0, $urandom};
      step();
    end
    redirect = 1'b0;
    stall = 1'b0;
    repeat (3) step();

    // 6: reset mid-stream, restart at RESET_PC
    do_reset("t6");
    rand_ready = 1'b0;
    lat_min = 1;
    lat_max = 1;
    wait_valid("t6_valid_timeout");
    chk("t6_restart_pc", s_pc, RESET_PC);
    chk("t6_restart_instr", 64'(s_instr), 64'h5A5A0013);
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
